sys_array_tile_scheduler: RTL and testbench

Tile scheduler that sequences the systolic-array fetcher across matrix products larger than the physical array. It accepts one product command (M×K weights times K×N data), splits it into tiles bounded by the array maxima and issues them one at a time. For each tile it emits a one-cycle start with tile offsets, sizes and an accumulate flag, then waits for the array's completion before issuing the next tile. It sits between the host command interface and the fetcher/array datapath.

---
 rtl/sys_array_tile_scheduler_pkg.sv | 28 ++
 rtl/sys_array_tile_scheduler_if.sv | 39 +++
 rtl/sys_array_tile_scheduler_counter.sv | 44 ++++
 rtl/sys_array_tile_scheduler.sv | 78 +++++++
 tb/tb_sys_array_tile_scheduler.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/sys_array_tile_scheduler_pkg.sv
// Shared types, default geometry and size helper for the systolic-array tile scheduler.
package sys_array_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } sched_state_e;

  localparam int DEF_DIM_WIDTH = 8;
  localparam int DEF_MAX_W     = 5;
  localparam int DEF_MAX_L     = 5;
  localparam int DEF_MAX_A_L   = 5;

  localparam int ROWS_W  = $clog2(DEF_MAX_W + 1);
  localparam int DEPTH_W = $clog2(DEF_MAX_L + 1);
  localparam int COLS_W  = $clog2(DEF_MAX_A_L + 1);

  // Wide enough for any dimension/limit pair the scheduler is built with.
  localparam int CALC_W = 16;

  function automatic logic [CALC_W-1:0] min_size(input logic [CALC_W-1:0] rem,
                                                 input logic [CALC_W-1:0] lim);
    return (rem < lim) ? rem : lim;
  endfunction

endpackage

// File: rtl/sys_array_tile_scheduler_if.sv
// Host command and fetcher/array tile bus of the tile scheduler.
interface sys_array_tile_scheduler_if
  import sys_array_pkg::*;
#(
  parameter int DIM_WIDTH = DEF_DIM_WIDTH,
  parameter int R_W       = ROWS_W,
  parameter int D_W       = DEPTH_W,
  parameter int C_W       = COLS_W
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [DIM_WIDTH-1:0] cmd_m;
  logic [DIM_WIDTH-1:0] cmd_k;
  logic [DIM_WIDTH-1:0] cmd_n;
  logic                 tile_start;
  logic [DIM_WIDTH-1:0] tile_row_off;
  logic [DIM_WIDTH-1:0] tile_k_off;
  logic [DIM_WIDTH-1:0] tile_col_off;
  logic [R_W-1:0]       tile_rows;
  logic [D_W-1:0]       tile_depth;
  logic [C_W-1:0]       tile_cols;
  logic                 tile_acc;
  logic                 tile_last_k;
  logic                 tile_done;
  logic                 busy;
  logic                 done;

  modport master (
    input  cmd_valid, cmd_m, cmd_k, cmd_n, tile_done,
    output cmd_ready, tile_start, tile_row_off, tile_k_off, tile_col_off,
           tile_rows, tile_depth, tile_cols, tile_acc, tile_last_k, busy, done
  );

  modport slave (
    output cmd_valid, cmd_m, cmd_k, cmd_n, tile_done,
    input  cmd_ready, tile_start, tile_row_off, tile_k_off, tile_col_off,
           tile_rows, tile_depth, tile_cols, tile_acc, tile_last_k, busy, done
  );
endinterface

// File: rtl/sys_array_tile_scheduler_counter.sv
// One tiling dimension: latched size, current offset, clipped tile size and wrap/last flags.
module sys_array_tile_counter
  import sys_array_pkg::*;
#(
  parameter int DIM_WIDTH = DEF_DIM_WIDTH,
  parameter int MAX       = DEF_MAX_W,
  parameter int SZ_W      = $clog2(MAX + 1)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clear,
  input  logic [DIM_WIDTH-1:0] dim_in,
  input  logic                 step,
  output logic [DIM_WIDTH-1:0] off,
  output logic [SZ_W-1:0]      size,
  output logic                 wrap,
  output logic                 last
);
  logic [DIM_WIDTH-1:0] dim_q;
  logic [DIM_WIDTH-1:0] off_q;
  logic [DIM_WIDTH-1:0] rem;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dim_q <= '0;
      off_q <= '0;
    end else if (clear) begin
      dim_q <= dim_in;
      off_q <= '0;
    end else if (step) begin
      off_q <= last ? '0 : off_q + DIM_WIDTH'(MAX);
    end
  end

  // Offsets always stay below the dimension, so rem never underflows.
  assign rem  = dim_q - off_q;
  assign size = SZ_W'(min_size(CALC_W'(rem), CALC_W'(MAX)));
  assign off  = off_q;
  // An empty dimension never reports last, keeping tile_last_k low out of reset.
  assign last = (dim_q != '0) &&
                (({1'b0, off_q} + (DIM_WIDTH+1)'(size)) == {1'b0, dim_q});
  assign wrap = step && last;

endmodule

// File: rtl/sys_array_tile_scheduler.sv
// Splits an MxK by KxN product into array-sized tiles, row/column/K loop order (K innermost).
// Optional abort input enabled by SYS_ARRAY_SCHED_ABORT_EN.
module sys_array_tile_scheduler
  import sys_array_pkg::*;
#(
  parameter int DIM_WIDTH     = DEF_DIM_WIDTH,
  parameter int ARRAY_MAX_W   = DEF_MAX_W,
  parameter int ARRAY_MAX_L   = DEF_MAX_L,
  parameter int ARRAY_MAX_A_L = DEF_MAX_A_L
) (
  input  logic clk,
  input  logic reset_n,
`ifdef SYS_ARRAY_SCHED_ABORT_EN
  input  logic abort,
`endif
  sys_array_tile_scheduler_if.master bus
);
  localparam int R_W = $clog2(ARRAY_MAX_W + 1);
  localparam int D_W = $clog2(ARRAY_MAX_L + 1);
  localparam int C_W = $clog2(ARRAY_MAX_A_L + 1);

  sched_state_e state_q, state_d;
  logic abort_act;
  logic cmd_take, zero_dim, all_last, step_k;
  logic k_wrap, k_last, c_wrap, c_last, row_wrap_unused, r_last;

`ifdef SYS_ARRAY_SCHED_ABORT_EN
  assign abort_act = abort && (state_q != IDLE);
`else
  assign abort_act = 1'b0;
`endif

  assign cmd_take = (state_q == IDLE) && bus.cmd_valid;
  assign zero_dim = (bus.cmd_m == '0) || (bus.cmd_k == '0) || (bus.cmd_n == '0);
  assign all_last = k_last && c_last && r_last;
  assign step_k   = (state_q == WAIT) && bus.tile_done && !all_last && !abort_act;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (bus.cmd_valid) state_d = zero_dim ? DONE : ISSUE;
      ISSUE: state_d = WAIT;
      WAIT:  if (bus.tile_done) state_d = all_last ? DONE : ISSUE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort_act) state_d = IDLE;
  end

  // Counters chained K -> column -> row; each wrap steps the next outer loop.
  sys_array_tile_counter #(.DIM_WIDTH(DIM_WIDTH), .MAX(ARRAY_MAX_L), .SZ_W(D_W)) u_k_cnt (
    .clk, .reset_n, .clear(cmd_take), .dim_in(bus.cmd_k), .step(step_k),
    .off(bus.tile_k_off), .size(bus.tile_depth), .wrap(k_wrap), .last(k_last)
  );

  sys_array_tile_counter #(.DIM_WIDTH(DIM_WIDTH), .MAX(ARRAY_MAX_A_L), .SZ_W(C_W)) u_col_cnt (
    .clk, .reset_n, .clear(cmd_take), .dim_in(bus.cmd_n), .step(k_wrap),
    .off(bus.tile_col_off), .size(bus.tile_cols), .wrap(c_wrap), .last(c_last)
  );

  sys_array_tile_counter #(.DIM_WIDTH(DIM_WIDTH), .MAX(ARRAY_MAX_W), .SZ_W(R_W)) u_row_cnt (
    .clk, .reset_n, .clear(cmd_take), .dim_in(bus.cmd_m), .step(c_wrap),
    .off(bus.tile_row_off), .size(bus.tile_rows), .wrap(row_wrap_unused), .last(r_last)
  );

  assign bus.cmd_ready   = (state_q == IDLE);
  assign bus.busy        = (state_q != IDLE);
  assign bus.tile_start  = (state_q == ISSUE) && !abort_act;
  assign bus.done        = (state_q == DONE) && !abort_act;
  assign bus.tile_acc    = (bus.tile_k_off != '0);
  assign bus.tile_last_k = k_last;

endmodule

// File: tb/tb_sys_array_tile_scheduler.sv
// Directed scoreboard bench for sys_array_tile_scheduler (define SYS_ARRAY_SCHED_ABORT_EN for abort case).
module tb_sys_array_tile_scheduler;
  import sys_array_pkg::*;

  typedef struct packed {
    logic [7:0] ro, ko, co;
    logic [2:0] r, d, c;
    logic       acc, lk;
  } tile_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic abort = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   done_pending = 0;
  tile_t exp_q[$];
  tile_t snap;

  sys_array_tile_scheduler_if bus ();

  sys_array_tile_scheduler dut (
    .clk     (clk),
    .reset_n (reset_n),
`ifdef SYS_ARRAY_SCHED_ABORT_EN
    .abort   (abort),
`endif
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic tile_t cur_tile();
    tile_t t;
    t.ro = bus.tile_row_off; t.ko = bus.tile_k_off; t.co = bus.tile_col_off;
    t.r = bus.tile_rows; t.d = bus.tile_depth; t.c = bus.tile_cols;
    t.acc = bus.tile_acc; t.lk = bus.tile_last_k;
    return t;
  endfunction

  function automatic tile_t mk(input int ro, ko, r, d, c);
    tile_t t;
    t.ro = 8'(ro); t.ko = 8'(ko); t.co = 8'd0;
    t.r = 3'(r); t.d = 3'(d); t.c = 3'(c);
    t.acc = (ko != 0); t.lk = (ko + d == 12) || (d == 5 && ko == 0 && c == 5);
    return t;
  endfunction

  // Monitor: every tile_start and done pulse is matched against the scoreboard.
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.tile_start) begin
        if (exp_q.size() == 0) check("unexpected_tile_start", 64'(cur_tile()), 64'd0);
        else check("tile_fields", 64'(cur_tile()), 64'(exp_q.pop_front()));
      end
      if (bus.done) begin
        check("done_expected", 64'(done_pending > 0), 64'd1);
        if (done_pending > 0) done_pending--;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input int m, k, n);
    check("cmd_ready_before_cmd", 64'(bus.cmd_ready), 64'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_m = 8'(m); bus.cmd_k = 8'(k); bus.cmd_n = 8'(n);
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  // Called one cycle after accept or after the previous tile_done edge (ISSUE cycle).
  task automatic run_tile(input int wait_cycles);
    check("tile_start_latency", 64'(bus.tile_start), 64'd1);
    tick();
    repeat (wait_cycles) tick();
    bus.tile_done = 1'b1;
    tick();
    bus.tile_done = 1'b0;
  endtask

  task automatic push_scn2(input int ntiles);
    tile_t all[6];
    all[0] = mk(0, 0, 5, 5, 3);  all[1] = mk(0, 5, 5, 5, 3);  all[2] = mk(0, 10, 5, 2, 3);
    all[3] = mk(5, 0, 2, 5, 3);  all[4] = mk(5, 5, 2, 5, 3);  all[5] = mk(5, 10, 2, 2, 3);
    for (int i = 0; i < ntiles; i++) exp_q.push_back(all[i]);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_ready"}, 64'(bus.cmd_ready), 64'd1);
    check({name, "_ctrl"}, {61'd0, bus.tile_start, bus.busy, bus.done}, 64'd0);
    check({name, "_fields"}, 64'(cur_tile()), 64'd0);
  endtask

  task automatic scenario_555();
    tile_t t;
    t = '{ro: 8'd0, ko: 8'd0, co: 8'd0, r: 3'd5, d: 3'd5, c: 3'd5, acc: 1'b0, lk: 1'b1};
    exp_q.push_back(t);
    done_pending++;
    send_cmd(5, 5, 5);
    run_tile(2);
    check("s1_done_after_last", 64'(bus.done), 64'd1);
    tick();
    check("s1_ready_after_done", {62'd0, bus.cmd_ready, bus.busy}, 64'd2);
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_m = '0; bus.cmd_k = '0; bus.cmd_n = '0;
    bus.tile_done = 1'b0;
    #1;
    check_reset_outputs("reset_initial");
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // Scenario 1: single full tile.
    scenario_555();

    // Scenario 2: 7x12x3, minimum tile period.
    push_scn2(6);
    done_pending++;
    send_cmd(7, 12, 3);
    for (int i = 0; i < 6; i++) run_tile(0);
    check("s2_done_after_last", 64'(bus.done), 64'd1);
    tick();

    // Scenario 3: zero dimension.
    done_pending++;
    send_cmd(0, 4, 4);
    check("s3_no_start", 64'(bus.tile_start), 64'd0);
    check("s3_done_one_cycle", 64'(bus.done), 64'd1);
    tick();
    check("s3_ready", 64'(bus.cmd_ready), 64'd1);

    // Scenario 4: spurious tile_done / cmd_valid, stable fields through long WAIT.
    bus.tile_done = 1'b1;
    tick();
    bus.tile_done = 1'b0;
    check("s4_idle_ignores_done", {62'd0, bus.cmd_ready, bus.busy}, 64'd2);
    exp_q.push_back('{ro: 8'd0, ko: 8'd0, co: 8'd0, r: 3'd5, d: 3'd5, c: 3'd5, acc: 1'b0, lk: 1'b1});
    done_pending++;
    send_cmd(5, 5, 5);
    bus.tile_done = 1'b1;
    bus.cmd_valid = 1'b1; bus.cmd_m = 8'd9; bus.cmd_k = 8'd9; bus.cmd_n = 8'd9;
    tick();
    bus.tile_done = 1'b0;
    check("s4_issue_ignores_done", {62'd0, bus.busy, bus.done}, 64'd2);
    snap = cur_tile();
    for (int i = 0; i < 10; i++) begin
      tick();
      check("s4_wait_stable", {28'd0, bus.tile_start, cur_tile()}, {29'd0, snap});
    end
    bus.cmd_valid = 1'b0;
    bus.tile_done = 1'b1;
    tick();
    bus.tile_done = 1'b0;
    check("s4_done", 64'(bus.done), 64'd1);
    tick();

    // Scenario 5: reset mid-WAIT of scenario 2, then a clean command.
    push_scn2(2);
    send_cmd(7, 12, 3);
    run_tile(1);
    tick();
    check("s5_in_wait", {62'd0, bus.busy, bus.tile_start}, 64'd2);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("s5_async_reset");
    tick(); tick();
    reset_n = 1'b1;
    tick();
    scenario_555();

`ifdef SYS_ARRAY_SCHED_ABORT_EN
    // Scenario 6: abort during WAIT of the third tile.
    push_scn2(3);
    send_cmd(7, 12, 3);
    run_tile(0);
    run_tile(0);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("s6_abort_idle", {62'd0, bus.cmd_ready, bus.busy}, 64'd2);
    repeat (4) tick();
    check("s6_still_idle", {62'd0, bus.cmd_ready, bus.busy}, 64'd2);
`endif

    repeat (3) tick();
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    check("no_pending_done", 64'(done_pending), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
